// File: rtl/iiitb_sqd_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package iiitb_sqd_pkg;

   localparam logic OVL_ON  = 1'b1;
   localparam logic OVL_OFF = 1'b0;

   localparam logic [7:0] DEF_PAT = 8'b0000_1010;
   localparam int         DEF_LEN = 4;
   localparam logic       DEF_OVL = OVL_ON;

   // Width needed to hold a length in the range 0..max_len inclusive.
   function automatic int sqd_len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/iiitb_sqd_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
module iiitb_sqd_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Holds at all-ones rather than wrapping back to zero.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (en && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/iiitb_sqd_param.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter.
module iiitb_sqd_param
   import iiitb_sqd_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(DEF_PAT),
   parameter int                 DEFAULT_LEN = DEF_LEN,
   parameter logic               DEFAULT_OVL = DEF_OVL
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            din,
   input  logic                            din_valid,
   input  logic                            cfg_load,
   input  logic [MAX_LEN-1:0]              cfg_pattern,
   input  logic [sqd_len_w(MAX_LEN)-1:0]   cfg_len,
   input  logic                            cfg_overlap,
   output logic                            y,
   output logic [CNT_W-1:0]                match_count,
   output logic                            cfg_err
);

   localparam int               LEN_W     = sqd_len_w(MAX_LEN);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic               err_q, err_d;
   logic               y_q, y_d;

   logic [MAX_LEN-1:0] hist_shift;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W:0]     fill_inc;
   logic               match;

   // Only the low len bits take part in the compare; fill_inc is one bit
   // wider so fill+1 never overflows when MAX_LEN is one below a power of 2.
   always_comb begin
      hist_shift = {hist_q[MAX_LEN-2:0], din};
      fill_inc   = (LEN_W+1)'(fill_q) + (LEN_W+1)'(1);
      len_mask   = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
   end

   // Config load beats an incoming bit; a non-overlapping match restarts fill
   // so no bit of the matched window can contribute to the next one.
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      err_d  = err_q;
      match  = 1'b0;
      if (cfg_load) begin
         pat_d  = cfg_pattern;
         len_d  = cfg_len;
         ovl_d  = cfg_overlap;
         err_d  = (cfg_len == '0) || (cfg_len > MAX_LEN_L);
         hist_d = '0;
         fill_d = '0;
      end else if (din_valid) begin
         hist_d = hist_shift;
         fill_d = (fill_q == MAX_LEN_L) ? fill_q : fill_inc[LEN_W-1:0];
         if (!err_q && (fill_inc >= {1'b0, len_q}) &&
             ((hist_shift & len_mask) == (pat_q & len_mask))) begin
            match = 1'b1;
         end
         if (match && (ovl_q == OVL_OFF)) begin
            fill_d = '0;
         end
      end
      y_d = match;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= DEFAULT_PAT;
         len_q  <= LEN_W'(DEFAULT_LEN);
         ovl_q  <= DEFAULT_OVL;
         err_q  <= 1'b0;
         y_q    <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         err_q  <= err_d;
         y_q    <= y_d;
      end
   end

   iiitb_sqd_sat_cnt #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .clear (reset),
      .en    (match),
      .count (match_count)
   );

   assign y       = y_q;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_iiitb_sqd_param.sv
// Directed bench for iiitb_sqd_param: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_iiitb_sqd_param;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = 8'h00;
   logic [3:0] cfg_len = 4'd0;
   logic       cfg_overlap = 1'b0;

   logic       y, y2;
   logic [7:0] match_count;
   logic [1:0] match_count2;
   logic       cfg_err, cfg_err2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   iiitb_sqd_param dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .y           (y),
      .match_count (match_count),
      .cfg_err     (cfg_err)
   );

   iiitb_sqd_param #(
      .CNT_W (2)
   ) dut2 (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .y           (y2),
      .match_count (match_count2),
      .cfg_err     (cfg_err2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic d, input logic v);
      din       = d;
      din_valid = v;
      cfg_load  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic applyConfig(input logic [7:0] pat, input logic [3:0] len,
                              input logic ovl, input logic d, input logic v);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      din         = d;
      din_valid   = v;
      cfg_load    = 1'b1;
      @(posedge clk);
      #1;
      cfg_load  = 1'b0;
      din_valid = 1'b0;
   endtask

   task automatic applyReset();
      reset     = 1'b1;
      din_valid = 1'b0;
      cfg_load  = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   logic [7:0] bits;
   logic [7:0] exp_y;

   initial begin
      // Power-on reset
      @(posedge clk);
      applyReset();
      checkOutput("rst_y", y, 0);
      checkOutput("rst_count", match_count, 0);
      checkOutput("rst_err", cfg_err, 0);
      checkOutput("rst_count2", match_count2, 0);

      // Defaults 1010 overlapping: stream 101010
      bits  = 8'b101010;
      exp_y = 8'b000101;
      for (int i = 5; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1);
         checkOutput($sformatf("def_y_bit%0d", 6 - i), y, exp_y[i]);
      end
      checkOutput("def_count", match_count, 2);
      checkOutput("def_count2", match_count2, 2);

      // Non-overlapping 1010: stream 10101010 matches at bits 4 and 8 only
      applyConfig(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0);
      checkOutput("novl_cfg_y", y, 0);
      checkOutput("novl_cfg_err", cfg_err, 0);
      bits  = 8'b10101010;
      exp_y = 8'b00010001;
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1);
         checkOutput($sformatf("novl_y_bit%0d", 8 - i), y, exp_y[i]);
      end
      checkOutput("novl_count", match_count, 4);
      checkOutput("novl_count2_sat", match_count2, 3);

      // Pattern 110 len 3; the bit presented with cfg_load must be dropped
      applyConfig(8'b0000_0110, 4'd3, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      checkOutput("gap_y_a", y, 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("discard_y", y, 0);
      bits = 8'b110;
      for (int i = 2; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1);
         checkOutput($sformatf("gap_y_bit%0d", 3 - i), y, (i == 0) ? 1 : 0);
         if (i != 0) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("gap_idle_y1", y, 0);
            applyStimulus(1'b0, 1'b0);
            checkOutput("gap_idle_y2", y, 0);
         end
      end
      checkOutput("gap_count", match_count, 5);

      // Reset mid-pattern loses the partial match and restores defaults
      applyReset();
      checkOutput("rst2_count", match_count, 0);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      checkOutput("mid_y_pre", y, 0);
      applyReset();
      checkOutput("mid_rst_y", y, 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("mid_after_y", y, 0);
      checkOutput("mid_after_count", match_count, 0);
      bits = 8'b1010;
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1);
         checkOutput($sformatf("mid_full_y_bit%0d", 4 - i), y, (i == 0) ? 1 : 0);
      end
      checkOutput("mid_full_count", match_count, 1);

      // Saturation: 10 repeated six times gives five overlapping matches
      applyReset();
      for (int i = 0; i < 12; i++) begin
         applyStimulus((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
         checkOutput($sformatf("sat_y2_bit%0d", i + 1), y2, (i >= 3 && i % 2 == 1) ? 1 : 0);
      end
      checkOutput("sat_count2", match_count2, 3);
      checkOutput("sat_count", match_count, 5);

      // Invalid lengths flag cfg_err and suppress matching
      applyConfig(8'b0000_1010, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("len0_err", cfg_err, 1);
      bits = 8'b1010;
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1);
         checkOutput($sformatf("len0_y_bit%0d", 4 - i), y, 0);
      end
      checkOutput("len0_count", match_count, 5);
      applyConfig(8'b0000_1010, 4'd9, 1'b1, 1'b0, 1'b0);
      checkOutput("len9_err", cfg_err, 1);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1);
         checkOutput($sformatf("len9_y_bit%0d", 4 - i), y, 0);
      end

      // Valid reload clears the error; bits above len are ignored
      applyConfig(8'hFA, 4'd4, 1'b1, 1'b0, 1'b0);
      checkOutput("len4_err", cfg_err, 0);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1);
         checkOutput($sformatf("len4_y_bit%0d", 4 - i), y, (i == 0) ? 1 : 0);
      end
      checkOutput("len4_count", match_count, 6);

      // Full-width pattern compares every history bit
      applyConfig(8'b1100_1010, 4'd8, 1'b1, 1'b0, 1'b0);
      checkOutput("len8_cfg_y", y, 0);
      bits = 8'b1100_1010;
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1);
         checkOutput($sformatf("len8_y_bit%0d", 8 - i), y, (i == 0) ? 1 : 0);
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("len8_y_fall", y, 0);
      checkOutput("len8_count", match_count, 7);
      checkOutput("len8_count2", match_count2, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
